// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants and the per-stage control bundle for pipe_controller_hz.
// Latency: none (types and constants only); backpressure: not applicable.
package pipe_ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       memtoReg;
    logic       branch;
    logic       pcs;
    logic       aluSrc;
    logic [1:0] flagWrite;
    logic [2:0] aluControl;
  } ctrl_d_t;

endpackage

// File: rtl/cond_eval.sv
// Condition check of the Execute-stage instruction against NZCV, plus the NZCV register.
// Latency: condExE combinational, flags update on the next edge; no backpressure.
module cond_eval
  import pipe_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] condE,
  input  logic [1:0] flagWriteE,
  input  logic [3:0] aluFlagsE,
  output logic       condExE,
  output logic [3:0] flagsQ
);

  logic n, z, c, v;
  assign {n, z, c, v} = flagsQ;

  always_comb begin
    condExE = 1'b0;
    case (condE)
      COND_EQ: condExE = z;
      COND_NE: condExE = ~z;
      COND_CS: condExE = c;
      COND_CC: condExE = ~c;
      COND_MI: condExE = n;
      COND_PL: condExE = ~n;
      COND_VS: condExE = v;
      COND_VC: condExE = ~v;
      COND_HI: condExE = c & ~z;
      COND_LS: condExE = ~(c & ~z);
      COND_GE: condExE = (n == v);
      COND_LT: condExE = (n != v);
      COND_GT: condExE = ~z & (n == v);
      COND_LE: condExE = ~(~z & (n == v));
      COND_AL: condExE = 1'b1;
      default: condExE = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flagsQ <= FLAG_RESET;
    end else begin
      if (flagWriteE[1] & condExE) flagsQ[3:2] <= aluFlagsE[3:2];
      if (flagWriteE[0] & condExE) flagsQ[1:0] <= aluFlagsE[1:0];
    end
  end

endmodule

// File: rtl/pipe_controller_hz.sv
// Hazard-aware pipelined ARM-subset controller: decode, D/E/M/W control registers, NZCV. Macro EARLY_BRANCH_EN.
// Latency: Decode to W outputs 3 edges, BranchTakenE 1 edge; no backpressure (FlushE bubbles D/E).
module pipe_controller_hz
  import pipe_ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W  = 2,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          InstrD,
  input  logic [3:0]           ALUFlagsE,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 MemtoRegE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic                 BranchTakenE,
  output logic                 PCWrPendingF,
  output logic [3:0]           FlagsQ
);

  // InstrD holds instruction bits [31:12]
  logic [1:0] op;
  logic [3:0] cmd, rd;
  logic       sBit;
  assign op   = InstrD[15:14];
  assign cmd  = InstrD[12:9];
  assign sBit = InstrD[8];
  assign rd   = InstrD[3:0];

  ctrl_d_t ctrlD, ctrlE;
  logic [3:0] condE;
  logic condExE, pcSrcE, pcsPendD, pcsPendE, pcsM, memtoRegM, pcSrcM;

  always_comb begin
    ctrlD   = '0;
    RegSrcD = 2'b00;
    ImmSrcD = 2'b00;
    case (op)
      OP_DP: begin
        ctrlD.aluSrc    = InstrD[13];
        ctrlD.regWrite  = 1'b1;
        ctrlD.flagWrite = {sBit, 1'b0};
        case (cmd)
          CMD_ADD: begin ctrlD.aluControl = ALU_ADD; ctrlD.flagWrite[0] = sBit; end
          CMD_SUB: begin ctrlD.aluControl = ALU_SUB; ctrlD.flagWrite[0] = sBit; end
          CMD_AND: ctrlD.aluControl = ALU_AND;
          CMD_ORR: ctrlD.aluControl = ALU_ORR;
          CMD_EOR: begin
            if (ALUCTRL_W >= 3) ctrlD.aluControl = ALU_EOR;
            else begin ctrlD.regWrite = 1'b0; ctrlD.flagWrite = 2'b00; end
          end
          CMD_CMP: begin
            ctrlD.regWrite = 1'b0;
            if (ALUCTRL_W >= 3) begin
              ctrlD.aluControl = ALU_SUB;
              ctrlD.flagWrite  = 2'b11;
            end else ctrlD.flagWrite = 2'b00;
          end
          default: begin ctrlD.regWrite = 1'b0; ctrlD.flagWrite = 2'b00; end
        endcase
      end
      OP_MEM: begin
        ImmSrcD         = 2'b01;
        ctrlD.aluSrc    = 1'b1;
        if (sBit) begin
          ctrlD.regWrite = 1'b1;
          ctrlD.memtoReg = 1'b1;
        end else begin
          ctrlD.memWrite = 1'b1;
          RegSrcD        = 2'b10;
        end
      end
      OP_BR: begin
        ctrlD.branch = 1'b1;
        RegSrcD      = 2'b01;
        ImmSrcD      = 2'b10;
        ctrlD.aluSrc = 1'b1;
      end
      default: ;
    endcase
    ctrlD.pcs = ((rd == 4'hF) & ctrlD.regWrite) | ctrlD.branch;
  end

  always_ff @(posedge clk) begin
    if (reset | FlushE) begin
      ctrlE <= '0;
      condE <= 4'h0;
    end else begin
      ctrlE <= ctrlD;
      condE <= InstrD[19:16];
    end
  end

  cond_eval #(.FLAG_RESET(FLAG_RESET)) uCondEval (
    .clk       (clk),
    .reset     (reset),
    .condE     (condE),
    .flagWriteE(ctrlE.flagWrite),
    .aluFlagsE (ALUFlagsE),
    .condExE   (condExE),
    .flagsQ    (FlagsQ)
  );

  assign ALUSrcE     = ctrlE.aluSrc;
  assign ALUControlE = ctrlE.aluControl[ALUCTRL_W-1:0];
  assign MemtoRegE   = ctrlE.memtoReg;

  // Upper ALU-code bit is dead when ALUCTRL_W=2; branch is dead without early redirect
  logic unusedBits;
  assign unusedBits = ^{ctrlE.aluControl, ctrlE.branch, InstrD[7:4]};

`ifdef EARLY_BRANCH_EN
  assign BranchTakenE = ctrlE.branch & condExE;
  assign pcSrcE       = ctrlE.pcs & ~ctrlE.branch & condExE;
  assign pcsPendD     = ctrlD.pcs & ~ctrlD.branch;
  assign pcsPendE     = ctrlE.pcs & ~ctrlE.branch;
`else
  assign BranchTakenE = 1'b0;
  assign pcSrcE       = ctrlE.pcs & condExE;
  assign pcsPendD     = ctrlD.pcs;
  assign pcsPendE     = ctrlE.pcs;
`endif

  assign PCWrPendingF = pcsPendD | pcsPendE | pcsM;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      memtoRegM <= 1'b0;
      pcSrcM    <= 1'b0;
      pcsM      <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteM <= ctrlE.regWrite & condExE;
      MemWriteM <= ctrlE.memWrite & condExE;
      memtoRegM <= ctrlE.memtoReg;
      pcSrcM    <= pcSrcE;
      pcsM      <= pcsPendE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= memtoRegM;
      PCSrcW    <= pcSrcM;
    end
  end

endmodule

// File: tb/tb_pipe_controller_hz.sv
// Directed bench for pipe_controller_hz: a 3-bit ALU-control instance plus a default 2-bit one on the same inputs.
module tb_pipe_controller_hz;

`ifdef EARLY_BRANCH_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;

  logic [1:0] RegSrcD, ImmSrcD, RegSrcD2, ImmSrcD2;
  logic       ALUSrcE, MemtoRegE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
  logic       BranchTakenE, PCWrPendingF;
  logic       ALUSrcE2, MemtoRegE2, RegWriteM2, MemWriteM2, RegWriteW2, MemtoRegW2, PCSrcW2;
  logic       BranchTakenE2, PCWrPendingF2;
  logic [2:0] ALUControlE;
  logic [1:0] ALUControlE2;
  logic [3:0] FlagsQ, FlagsQ2;

  pipe_controller_hz #(.ALUCTRL_W(3), .FLAG_RESET(4'b0001)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .FlagsQ(FlagsQ)
  );

  pipe_controller_hz dut2 (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
    .RegSrcD(RegSrcD2), .ImmSrcD(ImmSrcD2), .ALUSrcE(ALUSrcE2), .ALUControlE(ALUControlE2),
    .MemtoRegE(MemtoRegE2), .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2),
    .RegWriteW(RegWriteW2), .MemtoRegW(MemtoRegW2), .PCSrcW(PCSrcW2),
    .BranchTakenE(BranchTakenE2), .PCWrPendingF(PCWrPendingF2), .FlagsQ(FlagsQ2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op, input logic i,
                                     input logic [3:0] cmd, input logic s, input logic [3:0] rd);
    return {cond, op, i, cmd, s, 4'h0, rd};
  endfunction

  logic [19:0] nop, adds1, beq, strne, ldr, add4, cmp, eor, addpc, str, add1;

  initial begin
    nop   = {4'hE, 2'b11, 14'h0};
    adds1 = mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 4'h1);
    beq   = mk(4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 4'h0);
    strne = mk(4'h1, 2'b01, 1'b0, 4'b1100, 1'b0, 4'h2);
    ldr   = mk(4'hE, 2'b01, 1'b0, 4'b1100, 1'b1, 4'h3);
    add4  = mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h4);
    cmp   = mk(4'hE, 2'b00, 1'b0, 4'b1010, 1'b0, 4'h0);
    eor   = mk(4'hE, 2'b00, 1'b0, 4'b0001, 1'b0, 4'h5);
    addpc = mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'hF);
    str   = mk(4'hE, 2'b01, 1'b0, 4'b1100, 1'b0, 4'h2);
    add1  = mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1);

    reset = 1'b1; InstrD = nop; ALUFlagsE = 4'h0; FlushE = 1'b0;
    tick; tick;
    chk("rst_flags", FlagsQ, 4'b0001);
    chk("rst_flags2", FlagsQ2, 4'b0000);
    chk("rst_regwrw", RegWriteW, 0);
    chk("rst_pcsrcw", PCSrcW, 0);
    chk("rst_memwrm", MemWriteM, 0);
    reset = 1'b0;

    // ADDS r1: decode, execute with Z result, write back
    InstrD = adds1; #1;
    chk("adds_regsrc", RegSrcD, 2'b00);
    chk("adds_immsrc", ImmSrcD, 2'b00);
    chk("adds_pcpend", PCWrPendingF, 0);
    tick; InstrD = nop; ALUFlagsE = 4'b0100; #1;
    chk("adds_aluctl", ALUControlE, 0);
    chk("adds_alusrc", ALUSrcE, 0);
    tick; ALUFlagsE = 4'b0000;
    chk("adds_flags", FlagsQ, 4'b0100);
    chk("adds_regwrm", RegWriteM, 1);
    InstrD = adds1;
    tick;
    chk("adds_regwrw", RegWriteW, 1);
    chk("adds_memtow", MemtoRegW, 0);

    // clear Z, then ADDS setting Z immediately followed by BEQ
    InstrD = adds1; ALUFlagsE = 4'b0000;
    tick;
    chk("clr_flags", FlagsQ, 4'b0000);
    InstrD = beq; ALUFlagsE = 4'b0100; #1;
    chk("beq_regsrc", RegSrcD, 2'b01);
    chk("beq_immsrc", ImmSrcD, 2'b10);
    chk("beq_pcpend_d", PCWrPendingF, EARLY ? 0 : 1);
    tick; InstrD = nop; ALUFlagsE = 4'b0000; #1;
    chk("beq_flags", FlagsQ, 4'b0100);
    chk("beq_taken", BranchTakenE, EARLY ? 1 : 0);
    chk("beq_taken2", BranchTakenE2, EARLY ? 1 : 0);
    chk("beq_pcpend_e", PCWrPendingF, EARLY ? 0 : 1);
    tick; tick;
    chk("beq_pcsrcw", PCSrcW, EARLY ? 0 : 1);

    // STRNE with Z=1 must not store
    InstrD = strne; #1;
    chk("str_regsrc", RegSrcD, 2'b10);
    chk("str_immsrc", ImmSrcD, 2'b01);
    tick; InstrD = nop; #1;
    chk("str_alusrc", ALUSrcE, 1);
    chk("str_aluctl", ALUControlE, 0);
    tick;
    chk("strne_z1_memwr", MemWriteM, 0);
    chk("strne_z1_flags", FlagsQ, 4'b0100);

    // clear Z, then STRNE stores
    InstrD = adds1;
    tick; InstrD = strne; ALUFlagsE = 4'b0000;
    tick; InstrD = nop;
    chk("strne_z0_flags", FlagsQ, 4'b0000);
    tick;
    chk("strne_z0_memwr", MemWriteM, 1);
    chk("strne_z0_regwr", RegWriteM, 0);

    // LDR followed by a flushed ADD
    InstrD = ldr; #1;
    chk("ldr_regsrc", RegSrcD, 2'b00);
    tick; InstrD = add4; FlushE = 1'b1; #1;
    chk("ldr_memtoe", MemtoRegE, 1);
    tick; InstrD = nop; FlushE = 1'b0; #1;
    chk("flush_memtoe", MemtoRegE, 0);
    chk("ldr_regwrm", RegWriteM, 1);
    tick;
    chk("bubble_regwrm", RegWriteM, 0);
    chk("bubble_memwrm", MemWriteM, 0);
    chk("ldr_memtow", MemtoRegW, 1);

    // CMP (S=0) then EOR; only the 3-bit instance knows them
    InstrD = cmp;
    tick; InstrD = eor; ALUFlagsE = 4'b1000; #1;
    chk("cmp_aluctl", ALUControlE, 1);
    chk("cmp_aluctl2", ALUControlE2, 0);
    tick; ALUFlagsE = 4'b0000; InstrD = addpc; #1;
    chk("cmp_flags", FlagsQ, 4'b1000);
    chk("cmp_flags2", FlagsQ2, 4'b0000);
    chk("eor_aluctl", ALUControlE, 4);
    chk("eor_aluctl2", ALUControlE2, 0);
    chk("addpc_pcpend", PCWrPendingF, 1);
    tick; InstrD = str;
    chk("cmp_regwrw", RegWriteW, 0);
    chk("eor_regwrm", RegWriteM, 1);
    chk("eor_regwrm2", RegWriteM2, 0);
    tick; InstrD = add1; #1;
    chk("addpc_pcpend_m", PCWrPendingF, 1);

    // three writes in flight, then reset
    tick;
    chk("pre_regwrw", RegWriteW, 1);
    chk("pre_pcsrcw", PCSrcW, 1);
    chk("pre_memwrm", MemWriteM, 1);
    InstrD = nop; reset = 1'b1;
    tick; #1;
    chk("kill_regwrw", RegWriteW, 0);
    chk("kill_memwrm", MemWriteM, 0);
    chk("kill_regwrm", RegWriteM, 0);
    chk("kill_pcsrcw", PCSrcW, 0);
    chk("kill_pcpend", PCWrPendingF, 0);
    chk("kill_flags", FlagsQ, 4'b0001);
    chk("kill_flags2", FlagsQ2, 4'b0000);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
